// File: rtl/mcc_seq_divider.sv
// rtl/mcc_seq_divider.sv - sequential restoring divider, 2N/N bits, one quotient bit per cycle
// Optional two's complement operation: define MCC_DIV_SIGNED_EN.
module mcc_seq_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(2*N+1);
  localparam logic [CW-1:0] LAST = CW'(2*N);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  dq;
  logic [N-1:0]    rem;
  logic [N-1:0]    dvs;

  logic [N:0]      t;
  logic [N:0]      b;
  logic [N:0]      d;
  logic [N:0]      c;
  logic            qbit;

  logic [2*N-1:0]  a_mag;
  logic [N-1:0]    b_mag;

`ifdef MCC_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
  assign a_mag = dividend[2*N-1] ? -dividend : dividend;
  assign b_mag = divisor[N-1]    ? -divisor  : divisor;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  // Trial subtraction t - dvs as a Manchester carry chain; since t < 2*dvs,
  // sum bit N is set exactly when t >= dvs.
  always_comb begin
    t    = {rem, dq[2*N-1]};
    b    = {1'b0, ~dvs};
    c    = '0;
    d    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      c[i+1] = (t[i] & b[i]) | ((t[i] ^ b[i]) & c[i]);
      d[i]   = t[i] ^ b[i] ^ c[i];
    end
    d[N] = t[N] ^ b[N] ^ c[N];
    qbit = d[N];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      dq          <= '0;
      rem         <= '0;
      dvs         <= '0;
`ifdef MCC_DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              dvs   <= b_mag;
              dq    <= a_mag;
              rem   <= '0;
              cnt   <= '0;
`ifdef MCC_DIV_SIGNED_EN
              neg_q <= dividend[2*N-1] ^ divisor[N-1];
              neg_r <= dividend[2*N-1];
`endif
            end
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            // Extra cycle after the last iteration registers (and sign-fixes) the result.
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef MCC_DIV_SIGNED_EN
            quotient  <= neg_q ? -dq : dq;
            remainder <= neg_r ? -rem : rem;
`else
            quotient  <= dq;
            remainder <= rem;
`endif
          end else begin
            dq  <= {dq[2*N-2:0], qbit};
            rem <= qbit ? d[N-1:0] : t[N-1:0];
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            in_ready    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
